// File: rtl/cog_cap.sv
// Pin period / high-time capture unit for one cog.
// Measures the cycle distance between start edges on a selected pin.
module cog_cap (
  input  logic        clk_cog,
  input  logic        res,
  input  logic        setcap,
  input  logic [31:0] data,
  input  logic        clrvld,
  input  logic [31:0] pin_in,
  output logic [31:0] period,
  output logic [31:0] high,
  output logic        valid,
  output logic        overrun,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  cfg_q, cfg_d;
  logic [2:0]  sync_q, sync_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hcnt_q, hcnt_d;
  logic [31:0] period_q, period_d;
  logic [31:0] high_q, high_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;
  logic        ovf_q, ovf_d;

  logic rise_m, fall_m, start, act, sat, new_on;
  logic unused_data;

  assign unused_data = ^data[31:7];

  // sync_q[0]=s1, [1]=s2, [2]=s3
  assign rise_m = (cfg_q[6:5] == 2'b01);
  assign fall_m = (cfg_q[6:5] == 2'b10);
  assign start  = (rise_m & sync_q[1] & ~sync_q[2])
                | (fall_m & ~sync_q[1] & sync_q[2]);
  assign act    = (rise_m & sync_q[1]) | (fall_m & ~sync_q[1]);
  assign sat    = &cnt_q;
  assign new_on = data[6] ^ data[5];

  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      sync_q    <= '0;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (setcap) begin
      state_d = new_on ? ARM : IDLE;
    end else begin
      unique case (1'b1)
        (state_q == ARM) && start:          state_d = MEAS;
        (state_q == MEAS) && !start && sat: state_d = ARM;
        default:                            state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cfg_d     = cfg_q;
    sync_d    = {sync_q[1:0], pin_in[cfg_q[4:0]]};
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    ovf_d     = ovf_q;
    if (clrvld) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    // setcap overrides edges, captures and saturation alike
    if (setcap) begin
      cfg_d     = data[6:0];
      cnt_d     = '0;
      hcnt_d    = '0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
      ovf_d     = 1'b0;
    end else if (state_q == IDLE) begin
      cnt_d  = '0;
      hcnt_d = '0;
    end else if (start) begin
      cnt_d  = 32'd1;
      hcnt_d = 32'd1;
      if (state_q == MEAS) begin
        period_d  = cnt_q;
        high_d    = hcnt_q;
        valid_d   = 1'b1;
        overrun_d = valid_q;
      end
    end else if (state_q == MEAS) begin
      if (sat) begin
        ovf_d  = 1'b1;
        cnt_d  = '0;
        hcnt_d = '0;
      end else begin
        cnt_d = cnt_q + 32'd1;
        if (act) hcnt_d = hcnt_q + 32'd1;
      end
    end
  end

  assign period  = period_q;
  assign high    = high_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_cog_cap.sv
// Bench for cog_cap: directed scenarios plus random waveforms
// compared against an edge-list model of the sampled pin history.
module tb_cog_cap;

  logic        clk_cog = 1'b0;
  logic        res     = 1'b1;
  logic        setcap  = 1'b0;
  logic        clrvld  = 1'b0;
  logic [31:0] data    = '0;
  logic [31:0] pin_in  = '0;
  logic [31:0] period, high;
  logic        valid, overrun, ovf;

  int checks = 0;
  int errors = 0;
  int cur_sel = 0;
  bit cur_m10 = 1'b0;
  bit hist[$];
  int last_period = 0;
  int last_high = 0;

  cog_cap dut (
    .clk_cog(clk_cog),
    .res    (res),
    .setcap (setcap),
    .data   (data),
    .clrvld (clrvld),
    .pin_in (pin_in),
    .period (period),
    .high   (high),
    .valid  (valid),
    .overrun(overrun),
    .ovf    (ovf)
  );

  always #5 clk_cog = ~clk_cog;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit v);
    @(negedge clk_cog);
    pin_in = $urandom;
    pin_in[cur_sel] = v;
    hist.push_back(v);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(cur_m10);
  endtask

  task automatic config_cap(input int sel, input bit m10,
                            input logic [31:0] d);
    repeat (4) begin
      @(negedge clk_cog);
      pin_in = m10 ? '1 : '0;
    end
    @(negedge clk_cog);
    data = d;
    setcap = 1'b1;
    cur_sel = sel;
    cur_m10 = m10;
    @(negedge clk_cog);
    setcap = 1'b0;
    data = $urandom;
    idle(4);
    hist.delete();
  endtask

  // n periods of `act` active cycles each, then one closing start edge
  task automatic wave(input int per, input int act, input int n);
    repeat (n) begin
      repeat (act) tick(!cur_m10);
      repeat (per - act) tick(cur_m10);
    end
    tick(!cur_m10);
    idle(5);
  endtask

  task automatic check_model(input string tag);
    int e[$];
    bit prev;
    int a, b, h;
    prev = cur_m10;
    foreach (hist[i]) begin
      if (cur_m10 ? (prev && !hist[i]) : (!prev && hist[i]))
        e.push_back(i);
      prev = hist[i];
    end
    if (e.size() >= 2) begin
      a = e[e.size() - 2];
      b = e[e.size() - 1];
      h = 0;
      for (int i = a; i < b; i++) if (hist[i] != cur_m10) h++;
      last_period = b - a;
      last_high = h;
    end
    chk({tag, "_period"}, period, 32'(last_period));
    chk({tag, "_high"}, high, 32'(last_high));
    chk({tag, "_valid"}, {31'd0, valid}, {31'd0, e.size() >= 2});
    chk({tag, "_overrun"}, {31'd0, overrun}, {31'd0, e.size() >= 3});
    chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
  endtask

  initial begin
    int sel, per, act, n;
    bit m10;

    // reset state
    repeat (3) @(negedge clk_cog);
    chk("rst_period", period, 32'd0);
    chk("rst_high", high, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    res = 1'b0;

    // rising mode, period 100 high 25, 3-cycle latency
    config_cap(3, 1'b0, 32'h23);
    repeat (25) tick(1'b1);
    repeat (75) tick(1'b0);
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    chk("lat_early_valid", {31'd0, valid}, 32'd0);
    tick(1'b1);
    chk("lat_valid", {31'd0, valid}, 32'd1);
    chk("lat_period", period, 32'd100);
    chk("lat_high", high, 32'd25);
    repeat (20) tick(1'b1);
    idle(5);
    check_model("rise100");

    // falling mode on same square wave
    config_cap(3, 1'b1, 32'h43);
    repeat (75) tick(1'b0);
    repeat (25) tick(1'b1);
    tick(1'b0);
    idle(5);
    chk("fall_period", period, 32'd100);
    chk("fall_high", high, 32'd75);
    check_model("fall100");

    // overrun, clrvld, clrvld on capture cycle
    config_cap(3, 1'b0, 32'h23);
    wave(10, 4, 2);
    check_model("ovr");
    clrvld = 1'b1;
    tick(1'b0);
    clrvld = 1'b0;
    chk("clr_valid", {31'd0, valid}, 32'd0);
    chk("clr_overrun", {31'd0, overrun}, 32'd0);
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    clrvld = 1'b1;
    tick(1'b1);
    clrvld = 1'b0;
    chk("clrcap_valid", {31'd0, valid}, 32'd1);
    chk("clrcap_overrun", {31'd0, overrun}, 32'd0);

    // setcap coincident with a start edge
    config_cap(3, 1'b0, 32'h23);
    repeat (5) tick(1'b1);
    repeat (5) tick(1'b0);
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    data = 32'h23;
    setcap = 1'b1;
    tick(1'b1);
    setcap = 1'b0;
    chk("setedge_valid", {31'd0, valid}, 32'd0);
    repeat (5) tick(1'b1);
    repeat (5) tick(1'b0);
    repeat (5) tick(1'b1);
    repeat (5) tick(1'b0);
    chk("setedge_arm_valid", {31'd0, valid}, 32'd0);
    tick(1'b1);
    idle(5);
    chk("setedge_cap_valid", {31'd0, valid}, 32'd1);
    chk("setedge_period", period, 32'd10);
    chk("setedge_high", high, 32'd5);

    // saturation with a static pin
    config_cap(3, 1'b0, 32'h23);
    tick(1'b1);
    repeat (5) tick(1'b1);
    force dut.cnt_q = 32'hFFFF_FFF0;
    #1 release dut.cnt_q;
    repeat (40) tick(1'b1);
    chk("sat_ovf", {31'd0, ovf}, 32'd1);
    chk("sat_valid", {31'd0, valid}, 32'd0);
    chk("sat_period", period, 32'd10);
    clrvld = 1'b1;
    tick(1'b1);
    clrvld = 1'b0;
    chk("sat_clr_ovf", {31'd0, ovf}, 32'd1);
    repeat (3) tick(1'b0);
    repeat (5) tick(1'b1);
    repeat (5) tick(1'b0);
    chk("sat_arm_valid", {31'd0, valid}, 32'd0);
    tick(1'b1);
    idle(5);
    chk("sat_cap_valid", {31'd0, valid}, 32'd1);
    chk("sat_cap_period", period, 32'd10);
    chk("sat_cap_ovf", {31'd0, ovf}, 32'd1);

    // random waveforms against the edge model
    for (int it = 0; it < 10; it++) begin
      sel = $urandom_range(0, 31);
      m10 = 1'($urandom_range(0, 1));
      data = $urandom;
      data[4:0] = 5'(sel);
      data[6:5] = m10 ? 2'b10 : 2'b01;
      config_cap(sel, m10, data);
      n = $urandom_range(1, 4);
      repeat (n) begin
        per = $urandom_range(3, 40);
        act = $urandom_range(1, per - 1);
        repeat (act) tick(!cur_m10);
        repeat (per - act) tick(cur_m10);
      end
      tick(!cur_m10);
      idle(5);
      check_model($sformatf("rnd%0d", it));
    end

    // reset in the middle of a measurement
    config_cap(3, 1'b0, 32'h23);
    wave(10, 3, 1);
    chk("prerst_valid", {31'd0, valid}, 32'd1);
    tick(1'b1);
    tick(1'b1);
    #2 res = 1'b1;
    #1;
    chk("midrst_period", period, 32'd0);
    chk("midrst_high", high, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_overrun", {31'd0, overrun}, 32'd0);
    chk("midrst_ovf", {31'd0, ovf}, 32'd0);
    #1 res = 1'b0;
    repeat (3) begin
      repeat (4) tick(1'b1);
      repeat (4) tick(1'b0);
    end
    chk("postrst_valid", {31'd0, valid}, 32'd0);
    chk("postrst_period", period, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cog_cap.md
COG_CAP -- requirements
Module: cog_cap

Interface
REQ-001 clk_cog  input  1  cog clock; all state SHALL change on its rising edge except under reset.
REQ-002 res  input  1  asynchronous, active-high reset; SHALL force all state to reset values immediately while high.
REQ-003 setcap  input  1  one-cycle strobe; SHALL load the configuration register from data.
REQ-004 data  input  32  configuration word: [4:0] pin select, [6:5] mode (00 off, 01 rising-edge period, 10 falling-edge period, 11 off), [31:7] ignored.
REQ-005 clrvld  input  1  one-cycle strobe; SHALL clear valid and overrun.
REQ-006 pin_in  input  32  asynchronous I/O pin levels.
REQ-007 period  output  32  last captured period, in clk_cog cycles.
REQ-008 high  output  32  cycles at the active level within the last captured period.
REQ-009 valid  output  1  sticky flag: new capture available.
REQ-010 overrun  output  1  sticky flag: a capture occurred while valid was already 1.
REQ-011 ovf  output  1  sticky flag: period counter saturated with no closing edge.

Function
REQ-012 Synchronizer: s1<=pin_in[sel], s2<=s1, s3<=s2 every cycle, regardless of state.
REQ-013 Start edge: s2&!s3 in mode 01 and !s2&s3 in mode 10; never in off modes.
REQ-014 Active level: s2==1 in mode 01 and s2==0 in mode 10.
REQ-015 States: IDLE (mode off), ARM (waiting for first start edge), MEAS (counting).
REQ-016 IDLE: counters held at 0; no captures; flags retain their values.
REQ-017 ARM->MEAS on start edge: cnt<=1, hcnt<=1.
REQ-018 In MEAS, each cycle with no start edge: cnt<=cnt+1; hcnt<=hcnt+1 when active level, else hold.
REQ-019 MEAS start edge: period<=cnt, high<=hcnt, valid<=1, overrun<=valid, cnt<=1, hcnt<=1; state stays MEAS.
REQ-020 Captured period therefore SHALL equal the exact cycle distance between consecutive start edges; latency from pin change to updated outputs SHALL be 3 cycles.
REQ-021 Saturation: in MEAS with cnt==32'hFFFFFFFF and no start edge: ovf<=1, state->ARM, counters cleared, no capture.
REQ-022 hcnt SHALL never exceed cnt; no arithmetic wraps.
REQ-023 setcap: config<=data, cnt<=0, hcnt<=0, valid<=0, overrun<=0, ovf<=0; state->ARM if the new mode is 01/10, else IDLE; overrides any same-cycle edge or saturation.
REQ-024 clrvld with a same-cycle capture: capture wins (valid=1); overrun<=0 for that cycle's clear, then overrun<=old valid per REQ-019 (capture wins).
REQ-025 clrvld alone SHALL NOT clear ovf; only setcap or res clears ovf.
REQ-026 Changing pin_in[sel] while in MEAS SHALL NOT take effect until setcap; the select is used only from the config register.

Reset
REQ-027 On res: config=0 (IDLE), s1/s2/s3=0, cnt=hcnt=0, period=0, high=0, valid=0, overrun=0, ovf=0.
REQ-028 Reset asserted mid-measurement SHALL abort without capture; after release the block stays IDLE until setcap.

Verification
REQ-029 setcap data=0x23 (pin 3, rising); square wave on pin 3, period 100, high 25 -> after second rising edge period=100, high=25, valid=1 three cycles after the edge.
REQ-030 Same config, mode 10 (data=0x43) -> period=100, high=75.
REQ-031 Two captures with no clrvld -> overrun=1; clrvld -> valid=0, overrun=0; clrvld on the capture cycle -> valid=1.
REQ-032 Single rising edge then pin static; cnt forced near 32'hFFFFFFF0 -> ovf=1 after saturation, state ARM, period unchanged.
REQ-033 setcap on the same cycle as a start edge -> no capture, valid=0, counters 0, state ARM.
REQ-034 res pulsed mid-MEAS -> all outputs 0 immediately; subsequent edges produce no capture until setcap.
